// File: rtl/pmem_pkg.sv
// Shared types for the pmem responder: line type, FSM states and line geometry.
package pmem_pkg;

    localparam int LINE_OFFSET_BITS = 5;
    localparam int LINE_BITS        = 256;

    typedef logic [LINE_BITS-1:0] line_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/pmem_line_array.sv
// Line storage for the pmem responder: one combinational read port, one
// synchronous write port, and a synchronous clear of every line on reset.
module pmem_line_array
    import pmem_pkg::*;
#(
    parameter int NUM_LINES = 16,
    parameter int IDX_W     = $clog2(NUM_LINES)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic [IDX_W-1:0]     waddr,
    input  logic [LINE_BITS-1:0] wdata,
    input  logic [IDX_W-1:0]     raddr,
    output logic [LINE_BITS-1:0] rdata
);

    line_t lines [NUM_LINES];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                lines[i] <= '0;
            end
        end else if (we) begin
            lines[waddr] <= wdata;
        end
    end

    assign rdata = lines[raddr];

endmodule

// File: rtl/pmem_responder.sv
// Memory-side responder for the cache pmem handshake: fixed-latency line
// reads and writes with abort, back-to-back service and a sticky protocol flag.
module pmem_responder
    import pmem_pkg::*;
#(
    parameter int LATENCY   = 4,
    parameter int NUM_LINES = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          pmem_address,
    input  logic                 pmem_read,
    input  logic                 pmem_write,
    input  logic [LINE_BITS-1:0] pmem_wdata,
    output logic [LINE_BITS-1:0] pmem_rdata,
    output logic                 pmem_resp,
    output logic                 proto_err
);

    localparam int         IDX_W    = $clog2(NUM_LINES);
    localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

    state_t           state;
    logic [7:0]       count;
    logic [IDX_W-1:0] line_idx;
    line_t            wdata_q;
    logic             is_write;
    logic [IDX_W-1:0] req_idx;
    logic [IDX_W-1:0] rd_idx;
    line_t            array_rdata;
    logic             commit;
    logic             unused_addr_bits;

    assign req_idx          = pmem_address[LINE_OFFSET_BITS +: IDX_W];
    assign unused_addr_bits = ^{pmem_address[31:LINE_OFFSET_BITS+IDX_W],
                                pmem_address[LINE_OFFSET_BITS-1:0]};

    // In IDLE the read port looks at the live address so a LATENCY==1 read
    // can load rdata on the accepting edge; afterwards it uses the latched index.
    assign rd_idx = (state == IDLE) ? req_idx : line_idx;
    assign commit = (state == RESP) && is_write;

    pmem_line_array #(
        .NUM_LINES (NUM_LINES),
        .IDX_W     (IDX_W)
    ) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (commit),
        .waddr (line_idx),
        .wdata (wdata_q),
        .raddr (rd_idx),
        .rdata (array_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            count      <= '0;
            line_idx   <= '0;
            wdata_q    <= '0;
            is_write   <= 1'b0;
            pmem_resp  <= 1'b0;
            pmem_rdata <= '0;
            proto_err  <= 1'b0;
        end else begin
            pmem_resp <= 1'b0;
            case (state)
                IDLE: begin
                    if (pmem_read || pmem_write) begin
                        line_idx <= req_idx;
                        wdata_q  <= pmem_wdata;
                        is_write <= pmem_write;
                        count    <= CNT_LOAD;
                        if (pmem_read && pmem_write) begin
                            proto_err <= 1'b1;
                        end
                        if (CNT_LOAD == 8'd0) begin
                            state     <= RESP;
                            pmem_resp <= 1'b1;
                            if (!pmem_write) begin
                                pmem_rdata <= array_rdata;
                            end
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                // Both requests dropping is an abort; it wins over completion.
                WAIT: begin
                    if (!pmem_read && !pmem_write) begin
                        state <= IDLE;
                        count <= '0;
                    end else begin
                        count <= count - 8'd1;
                        if (count == 8'd1) begin
                            state     <= RESP;
                            pmem_resp <= 1'b1;
                            if (!is_write) begin
                                pmem_rdata <= array_rdata;
                            end
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pmem_responder.sv
// Self-checking bench: two responders (LATENCY 4 and 1) driven by directed
// vectors, hand-written corner sequences and random transactions vs a line model.
module tb_pmem_responder;
    import pmem_pkg::*;

    localparam int NL = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr  [2];
    logic        rd    [2];
    logic        wr    [2];
    line_t       wdata [2];
    line_t       rdata [2];
    logic        resp  [2];
    logic        perr  [2];

    int checks   = 0;
    int failures = 0;

    line_t model_mem  [2][NL];
    line_t last_rdata [2];
    bit    model_perr [2];

    typedef struct {
        int          d;
        bit          r;
        bit          w;
        logic [31:0] a;
        line_t       wd;
        line_t       exp_rdata;
        bit          exp_perr;
    } vec_t;

    always #5 clk = ~clk;

    pmem_responder #(.LATENCY(4), .NUM_LINES(NL)) dut4 (
        .clk(clk), .rst_n(rst_n), .pmem_address(addr[0]), .pmem_read(rd[0]),
        .pmem_write(wr[0]), .pmem_wdata(wdata[0]), .pmem_rdata(rdata[0]),
        .pmem_resp(resp[0]), .proto_err(perr[0])
    );

    pmem_responder #(.LATENCY(1), .NUM_LINES(NL)) dut1 (
        .clk(clk), .rst_n(rst_n), .pmem_address(addr[1]), .pmem_read(rd[1]),
        .pmem_write(wr[1]), .pmem_wdata(wdata[1]), .pmem_rdata(rdata[1]),
        .pmem_resp(resp[1]), .proto_err(perr[1])
    );

    function automatic int latOf(input int d);
        return (d == 0) ? 4 : 1;
    endfunction

    function automatic int idxOf(input logic [31:0] a);
        return int'(a[5 +: 4]);
    endfunction

    function automatic line_t randLine();
        line_t v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic line_t fillLine(input logic [31:0] word);
        line_t v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = word;
        return v;
    endfunction

    // Expected outcome of a completed transaction in memory terms.
    function automatic line_t modelApply(input int d, input bit r, input bit w,
                                         input logic [31:0] a, input line_t wd);
        if (w) begin
            model_mem[d][idxOf(a)] = wd;
            if (r) model_perr[d] = 1'b1;
        end else if (r) begin
            last_rdata[d] = model_mem[d][idxOf(a)];
        end
        return last_rdata[d];
    endfunction

    task automatic clearModel();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < NL; i++) model_mem[d][i] = '0;
            last_rdata[d] = '0;
            model_perr[d] = 1'b0;
        end
    endtask

    task automatic checkOutput(input string name, input line_t got, input line_t exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic applyStimulus(input int d, input bit r, input bit w,
                                 input logic [31:0] a, input line_t wd);
        addr[d]  = a;
        rd[d]    = r;
        wr[d]    = w;
        wdata[d] = wd;
    endtask

    task automatic doReset(input int cycles);
        @(negedge clk);
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) applyStimulus(d, 1'b0, 1'b0, '0, '0);
        repeat (cycles) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("reset resp d%0d", d), line_t'(resp[d]), '0);
            checkOutput($sformatf("reset rdata d%0d", d), rdata[d], '0);
            checkOutput($sformatf("reset perr d%0d", d), line_t'(perr[d]), '0);
        end
        rst_n = 1'b1;
        clearModel();
    endtask

    // Full handshake: checks response latency and single-cycle pulse,
    // returns rdata seen in the resp cycle and proto_err afterwards.
    task automatic runTxn(input int d, input bit r, input bit w, input logic [31:0] a,
                          input line_t wd, input bit perturb, input string name,
                          output line_t got_rdata, output logic got_perr);
        int lat;
        lat = -1;
        got_rdata = 'x;
        @(negedge clk);
        applyStimulus(d, r, w, a, wd);
        for (int k = 1; k <= 300 && lat < 0; k++) begin
            @(negedge clk);
            if (resp[d]) begin
                lat = k;
                got_rdata = rdata[d];
            end else if (perturb) begin
                addr[d]  = $urandom;
                wdata[d] = randLine();
            end
        end
        checkOutput({name, " latency"}, line_t'(lat), line_t'(latOf(d)));
        applyStimulus(d, 1'b0, 1'b0, addr[d], wdata[d]);
        @(negedge clk);
        checkOutput({name, " resp width"}, line_t'(resp[d]), '0);
        got_perr = perr[d];
    endtask

    vec_t  vecs [8];
    line_t got;
    logic  gp;
    line_t expv;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int    saw;
        int    t0;
        int    gap;
        line_t pat;

        rst_n = 1'b1;
        for (int d = 0; d < 2; d++) applyStimulus(d, 1'b0, 1'b0, '0, '0);
        doReset(2);

        // Directed table, applied in order after reset.
        vecs[0] = '{0, 1'b0, 1'b1, 32'h0000_0040, fillLine(32'hA5A5_A5A5), '0, 1'b0};
        vecs[1] = '{0, 1'b1, 1'b0, 32'h0000_0040, '0, fillLine(32'hA5A5_A5A5), 1'b0};
        vecs[2] = '{0, 1'b1, 1'b0, 32'h0000_0060, '0, '0, 1'b0};
        vecs[3] = '{0, 1'b0, 1'b1, 32'hF000_1040, fillLine(32'h5A5A_5A5A), '0, 1'b0};
        vecs[4] = '{0, 1'b1, 1'b0, 32'h0000_0040, '0, fillLine(32'h5A5A_5A5A), 1'b0};
        vecs[5] = '{1, 1'b0, 1'b1, 32'h0000_0080, fillLine(32'hC3C3_C3C3), '0, 1'b0};
        vecs[6] = '{1, 1'b1, 1'b0, 32'h0000_009F, '0, fillLine(32'hC3C3_C3C3), 1'b0};
        vecs[7] = '{1, 1'b1, 1'b0, 32'h0000_0040, '0, '0, 1'b0};
        for (int i = 0; i < 8; i++) begin
            expv = modelApply(vecs[i].d, vecs[i].r, vecs[i].w, vecs[i].a, vecs[i].wd);
            runTxn(vecs[i].d, vecs[i].r, vecs[i].w, vecs[i].a, vecs[i].wd, 1'b1,
                   $sformatf("vec%0d", i), got, gp);
            if (vecs[i].w) checkOutput($sformatf("vec%0d rdata held", i), got, last_rdata[vecs[i].d]);
            else checkOutput($sformatf("vec%0d rdata", i), got, vecs[i].exp_rdata);
            checkOutput($sformatf("vec%0d perr", i), line_t'(gp), line_t'(vecs[i].exp_perr));
        end

        // Abort: write to 0x20 dropped in cycle 2.
        doReset(1);
        saw = 0;
        @(negedge clk);
        applyStimulus(0, 1'b0, 1'b1, 32'h20, fillLine(32'hFFFF_FFFF));
        repeat (2) begin
            @(negedge clk);
            if (resp[0]) saw++;
        end
        applyStimulus(0, 1'b0, 1'b0, 32'h20, '0);
        repeat (8) begin
            @(negedge clk);
            if (resp[0]) saw++;
        end
        checkOutput("abort no resp", line_t'(saw), '0);
        expv = modelApply(0, 1'b1, 1'b0, 32'h20, '0);
        runTxn(0, 1'b1, 1'b0, 32'h20, '0, 1'b0, "abort readback", got, gp);
        checkOutput("abort readback rdata", got, '0);

        // Writeback to 0x20 followed by a fill of 0x60 in the cycle after resp.
        pat = fillLine(32'h0BAD_F00D);
        t0 = -1;
        @(negedge clk);
        applyStimulus(0, 1'b0, 1'b1, 32'h20, pat);
        for (int k = 1; k <= 50 && t0 < 0; k++) begin
            @(negedge clk);
            if (resp[0]) t0 = k;
        end
        checkOutput("b2b first latency", line_t'(t0), line_t'(4));
        applyStimulus(0, 1'b0, 1'b0, 32'h20, '0);
        expv = modelApply(0, 1'b0, 1'b1, 32'h20, pat);
        @(negedge clk);
        checkOutput("b2b resp low between", line_t'(resp[0]), '0);
        applyStimulus(0, 1'b1, 1'b0, 32'h60, '0);
        gap = -1;
        for (int j = 1; j <= 50 && gap < 0; j++) begin
            @(negedge clk);
            if (resp[0]) begin
                gap = j + 1;
                got = rdata[0];
            end
        end
        checkOutput("b2b resp gap", line_t'(gap), line_t'(5));
        expv = modelApply(0, 1'b1, 1'b0, 32'h60, '0);
        checkOutput("b2b fill rdata", got, '0);
        applyStimulus(0, 1'b0, 1'b0, 32'h60, '0);
        expv = modelApply(0, 1'b1, 1'b0, 32'h20, '0);
        runTxn(0, 1'b1, 1'b0, 32'h20, '0, 1'b0, "b2b wb readback", got, gp);
        checkOutput("b2b wb readback rdata", got, pat);

        // Simultaneous read and write: served as a write, sticky proto_err.
        pat = fillLine(32'h1234_5678);
        expv = modelApply(0, 1'b1, 1'b1, 32'h20, pat);
        runTxn(0, 1'b1, 1'b1, 32'h20, pat, 1'b0, "both", got, gp);
        checkOutput("both perr set", line_t'(gp), '1 >> 255);
        expv = modelApply(0, 1'b1, 1'b0, 32'h20, '0);
        runTxn(0, 1'b1, 1'b0, 32'h20, '0, 1'b0, "both readback", got, gp);
        checkOutput("both readback rdata", got, pat);
        checkOutput("both perr sticky", line_t'(gp), line_t'(model_perr[0]));

        // Reset in cycle 2 of a write drops it; the array is cleared.
        doReset(1);
        pat = fillLine(32'hDEAD_BEEF);
        expv = modelApply(0, 1'b0, 1'b1, 32'hA0, pat);
        runTxn(0, 1'b0, 1'b1, 32'hA0, pat, 1'b0, "pre-reset write", got, gp);
        saw = 0;
        @(negedge clk);
        applyStimulus(0, 1'b0, 1'b1, 32'hA0, fillLine(32'h7777_7777));
        repeat (2) begin
            @(negedge clk);
            if (resp[0]) saw++;
        end
        rst_n = 1'b0;
        applyStimulus(0, 1'b0, 1'b0, 32'hA0, '0);
        repeat (2) begin
            @(negedge clk);
            if (resp[0]) saw++;
        end
        rst_n = 1'b1;
        clearModel();
        repeat (6) begin
            @(negedge clk);
            if (resp[0]) saw++;
        end
        checkOutput("midreset no resp", line_t'(saw), '0);
        checkOutput("midreset perr", line_t'(perr[0]), '0);
        expv = modelApply(0, 1'b1, 1'b0, 32'hA0, '0);
        runTxn(0, 1'b1, 1'b0, 32'hA0, '0, 1'b0, "midreset readback", got, gp);
        checkOutput("midreset readback rdata", got, '0);

        // LATENCY=1: address change in the resp cycle must not affect rdata.
        pat = fillLine(32'h4040_4040);
        expv = modelApply(1, 1'b0, 1'b1, 32'h40, pat);
        runTxn(1, 1'b0, 1'b1, 32'h40, pat, 1'b0, "lat1 w40", got, gp);
        expv = modelApply(1, 1'b0, 1'b1, 32'h80, fillLine(32'h8080_8080));
        runTxn(1, 1'b0, 1'b1, 32'h80, fillLine(32'h8080_8080), 1'b0, "lat1 w80", got, gp);
        @(negedge clk);
        applyStimulus(1, 1'b1, 1'b0, 32'h40, '0);
        @(posedge clk);
        #1 addr[1] = 32'h80;
        @(negedge clk);
        checkOutput("lat1 resp cycle1", line_t'(resp[1]), line_t'(1));
        checkOutput("lat1 rdata", rdata[1], pat);
        applyStimulus(1, 1'b0, 1'b0, 32'h80, '0);
        expv = modelApply(1, 1'b1, 1'b0, 32'h40, '0);
        @(negedge clk);
        checkOutput("lat1 resp one cycle", line_t'(resp[1]), '0);
        checkOutput("lat1 rdata hold", rdata[1], pat);

        // Random transactions against the line model.
        for (int i = 0; i < 80; i++) begin
            int          d;
            int          op;
            bit          r;
            bit          w;
            logic [31:0] a;
            line_t       wd;
            d  = $urandom_range(0, 1);
            op = $urandom_range(0, 9);
            r  = (op == 0) || (op >= 5);
            w  = (op <= 4);
            a  = $urandom;
            wd = randLine();
            expv = modelApply(d, r, w, a, wd);
            runTxn(d, r, w, a, wd, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i), got, gp);
            checkOutput($sformatf("rnd%0d rdata", i), got, expv);
            checkOutput($sformatf("rnd%0d perr", i), line_t'(gp), line_t'(model_perr[d]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
